// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the Memory data-port arbiter: access modes, owner encoding
// and the request bundle carried by both requesters and the Memory-side mux.
package mem_port_arbiter_pkg;

  localparam logic [2:0] MEM_NONE = 3'd0;
  localparam logic [2:0] MEM_BYTE = 3'd1;
  localparam logic [2:0] MEM_HALF = 3'd2;
  localparam logic [2:0] MEM_WORD = 3'd3;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } MemOwner;

  // Modes stay raw 3-bit fields so any combination passes through untouched.
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic [2:0]  write_mode;
    logic [2:0]  read_mode;
    logic        unsigned_load;
  } MemRequest;

endpackage

// File: rtl/arb_grant_fsm.sv
// Owner FSM for the Memory data port: round-robin tie break on idle and a
// bounded run of consecutive fires while the other requester waits.
module arb_grant_fsm
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_GRANT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cpu_req,
  input  logic       i_ldr_req,
  output logic [1:0] o_owner,
  output logic       o_cpu_grant,
  output logic       o_ldr_grant
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_GRANT - 1);

  MemOwner    r_owner, r_last_owner;
  logic [7:0] r_hold_count;
  MemOwner    w_owner_nxt, w_last_nxt, w_y_owner;
  logic [7:0] w_hold_nxt;
  logic       w_x_req, w_y_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= OWN_IDLE;
      r_last_owner <= OWN_LDR;
      r_hold_count <= '0;
    end else begin
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_hold_count <= w_hold_nxt;
    end
  end

  // X is the current owner, Y the other requester.
  always_comb begin
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_hold_nxt  = r_hold_count;
    w_x_req     = (r_owner == OWN_CPU) ? i_cpu_req : i_ldr_req;
    w_y_req     = (r_owner == OWN_CPU) ? i_ldr_req : i_cpu_req;
    w_y_owner   = (r_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
    case (r_owner)
      OWN_IDLE: begin
        w_hold_nxt = '0;
        if (i_cpu_req && i_ldr_req)
          w_owner_nxt = (r_last_owner == OWN_LDR) ? OWN_CPU : OWN_LDR;
        else if (i_cpu_req)
          w_owner_nxt = OWN_CPU;
        else if (i_ldr_req)
          w_owner_nxt = OWN_LDR;
      end
      OWN_CPU, OWN_LDR: begin
        if (w_x_req && w_y_req && (r_hold_count == HOLD_LIMIT)) begin
          w_owner_nxt = w_y_owner;
          w_last_nxt  = r_owner;
          w_hold_nxt  = '0;
        end else if (!w_x_req) begin
          w_owner_nxt = w_y_req ? w_y_owner : OWN_IDLE;
          w_last_nxt  = r_owner;
          w_hold_nxt  = '0;
        end else if (w_y_req) begin
          w_hold_nxt = (r_hold_count == 8'hFF) ? r_hold_count : r_hold_count + 8'd1;
        end else begin
          w_hold_nxt = '0;
        end
      end
      default: begin
        w_owner_nxt = OWN_IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    o_owner     = r_owner;
    o_cpu_grant = (r_owner == OWN_CPU);
    o_ldr_grant = (r_owner == OWN_LDR);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares Memory's data port between the CPU load/store unit and the program
// loader; fires go straight to Memory, ack and read data return one cycle later.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_GRANT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpuReq,
  input  logic [31:0] cpuAddress,
  input  logic [31:0] cpuData,
  input  logic [2:0]  cpuWriteMode,
  input  logic [2:0]  cpuReadMode,
  input  logic        cpuUnsignedLoad,
  output logic        cpuGrant,
  output logic        cpuAck,
  output logic [31:0] cpuReadData,
  input  logic        ldrReq,
  input  logic [31:0] ldrAddress,
  input  logic [31:0] ldrData,
  input  logic [2:0]  ldrWriteMode,
  input  logic [2:0]  ldrReadMode,
  input  logic        ldrUnsignedLoad,
  output logic        ldrGrant,
  output logic        ldrAck,
  output logic [31:0] ldrReadData,
  output logic [31:0] memAddress,
  output logic [31:0] memData,
  output logic [2:0]  memWriteMode,
  output logic [2:0]  memReadMode,
  output logic        memUnsignedLoad,
  input  logic [31:0] memDataOutput
);

  logic [1:0]  w_owner;
  logic        w_cpu_fire, w_ldr_fire;
  MemRequest   w_cpu_bus, w_ldr_bus, w_mem_req;
  logic        r_cpu_ack, r_ldr_ack;
  logic [31:0] r_cpu_rdata, r_ldr_rdata;

  arb_grant_fsm #(.MAX_GRANT(MAX_GRANT)) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_cpu_req  (cpuReq),
    .i_ldr_req  (ldrReq),
    .o_owner    (w_owner),
    .o_cpu_grant(cpuGrant),
    .o_ldr_grant(ldrGrant)
  );

  assign w_cpu_bus  = {cpuAddress, cpuData, cpuWriteMode, cpuReadMode, cpuUnsignedLoad};
  assign w_ldr_bus  = {ldrAddress, ldrData, ldrWriteMode, ldrReadMode, ldrUnsignedLoad};
  assign w_cpu_fire = cpuReq && (w_owner == OWN_CPU);
  assign w_ldr_fire = ldrReq && (w_owner == OWN_LDR);

  // Driven only by the owner register, so an async reset drops both modes to
  // NONE at once and a write in flight never reaches Memory.
  always_comb begin
    w_mem_req            = '0;
    w_mem_req.write_mode = MEM_NONE;
    w_mem_req.read_mode  = MEM_NONE;
    if (w_cpu_fire)
      w_mem_req = w_cpu_bus;
    else if (w_ldr_fire)
      w_mem_req = w_ldr_bus;
  end

  assign memAddress      = w_mem_req.address;
  assign memData         = w_mem_req.data;
  assign memWriteMode    = w_mem_req.write_mode;
  assign memReadMode     = w_mem_req.read_mode;
  assign memUnsignedLoad = w_mem_req.unsigned_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_ack   <= 1'b0;
      r_ldr_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else begin
      r_cpu_ack <= w_cpu_fire;
      r_ldr_ack <= w_ldr_fire;
      if (w_cpu_fire && (cpuReadMode != MEM_NONE))
        r_cpu_rdata <= memDataOutput;
      if (w_ldr_fire && (ldrReadMode != MEM_NONE))
        r_ldr_rdata <= memDataOutput;
    end
  end

  assign cpuAck      = r_cpu_ack;
  assign ldrAck      = r_ldr_ack;
  assign cpuReadData = r_cpu_rdata;
  assign ldrReadData = r_ldr_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with a byte-addressed Memory model on the data port.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpuReq, cpuUnsignedLoad, ldrReq, ldrUnsignedLoad;
  logic [31:0] cpuAddress, cpuData, ldrAddress, ldrData;
  logic [2:0]  cpuWriteMode, cpuReadMode, ldrWriteMode, ldrReadMode;
  logic        cpuGrant, cpuAck, ldrGrant, ldrAck, memUnsignedLoad;
  logic [31:0] cpuReadData, ldrReadData, memAddress, memData, memDataOutput;
  logic [2:0]  memWriteMode, memReadMode;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] ldr_q[$];
  logic [31:0] cpu_last, ldr_last;
  int cpu_ack_cnt = 0, ldr_ack_cnt = 0, cpu_streak = 0, cpu_streak_max = 0;

  mem_port_arbiter #(.MAX_GRANT(8)) dut (
    .clk(clk), .rst(rst),
    .cpuReq(cpuReq), .cpuAddress(cpuAddress), .cpuData(cpuData),
    .cpuWriteMode(cpuWriteMode), .cpuReadMode(cpuReadMode),
    .cpuUnsignedLoad(cpuUnsignedLoad), .cpuGrant(cpuGrant), .cpuAck(cpuAck),
    .cpuReadData(cpuReadData),
    .ldrReq(ldrReq), .ldrAddress(ldrAddress), .ldrData(ldrData),
    .ldrWriteMode(ldrWriteMode), .ldrReadMode(ldrReadMode),
    .ldrUnsignedLoad(ldrUnsignedLoad), .ldrGrant(ldrGrant), .ldrAck(ldrAck),
    .ldrReadData(ldrReadData),
    .memAddress(memAddress), .memData(memData), .memWriteMode(memWriteMode),
    .memReadMode(memReadMode), .memUnsignedLoad(memUnsignedLoad),
    .memDataOutput(memDataOutput)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: little-endian bytes, write at posedge, combinational read.
  logic [7:0]  mem [0:65535];
  logic [15:0] ma;
  logic [31:0] mem_word;
  assign ma = memAddress[15:0];
  initial for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;

  always @(posedge clk) begin
    case (memWriteMode)
      MEM_BYTE: mem[ma] <= memData[7:0];
      MEM_HALF: begin
        mem[ma] <= memData[7:0]; mem[ma + 16'd1] <= memData[15:8];
      end
      MEM_WORD: begin
        mem[ma] <= memData[7:0];           mem[ma + 16'd1] <= memData[15:8];
        mem[ma + 16'd2] <= memData[23:16]; mem[ma + 16'd3] <= memData[31:24];
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_word = {mem[ma + 16'd3], mem[ma + 16'd2], mem[ma + 16'd1], mem[ma]};
    case (memReadMode)
      MEM_BYTE: memDataOutput = memUnsignedLoad ? {24'h0, mem_word[7:0]}
                                                : {{24{mem_word[7]}}, mem_word[7:0]};
      MEM_HALF: memDataOutput = memUnsignedLoad ? {16'h0, mem_word[15:0]}
                                                : {{16{mem_word[15]}}, mem_word[15:0]};
      MEM_WORD: memDataOutput = mem_word;
      default:  memDataOutput = 32'h0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // driver tasks: entered at a negedge, return at the negedge after the fire
  task automatic cpu_txn(input logic [2:0] wm, input logic [2:0] rm, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_rd, output int fire_c);
    int b = 0;
    cpuWriteMode = wm; cpuReadMode = rm; cpuUnsignedLoad = uns;
    cpuAddress = addr; cpuData = data; cpuReq = 1'b1;
    while (!cpuGrant && b < 50) begin @(negedge clk); b++; end
    check_eq("cpu_grant_wait", {31'h0, cpuGrant}, 32'h1);
    fire_c = cyc;
    if (rm != MEM_NONE) cpu_last = exp_rd;
    cpu_q.push_back(cpu_last);
    @(negedge clk);
    check_eq("cpu_ack_latency", {31'h0, cpuAck}, 32'h1);
  endtask

  task automatic ldr_txn(input logic [2:0] wm, input logic [2:0] rm, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_rd, output int fire_c);
    int b = 0;
    ldrWriteMode = wm; ldrReadMode = rm; ldrUnsignedLoad = uns;
    ldrAddress = addr; ldrData = data; ldrReq = 1'b1;
    while (!ldrGrant && b < 50) begin @(negedge clk); b++; end
    check_eq("ldr_grant_wait", {31'h0, ldrGrant}, 32'h1);
    fire_c = cyc;
    if (rm != MEM_NONE) ldr_last = exp_rd;
    ldr_q.push_back(ldr_last);
    @(negedge clk);
    check_eq("ldr_ack_latency", {31'h0, ldrAck}, 32'h1);
  endtask

  task automatic apply_reset();
    rst = 1'b0; cpuReq = 1'b0; ldrReq = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_grants", {30'h0, cpuGrant, ldrGrant}, 32'h0);
    check_eq("rst_acks", {30'h0, cpuAck, ldrAck}, 32'h0);
    check_eq("rst_cpu_rdata", cpuReadData, 32'h0);
    check_eq("rst_ldr_rdata", ldrReadData, 32'h0);
    check_eq("rst_mem_modes", {26'h0, memWriteMode, memReadMode}, 32'h0);
    check_eq("rst_mem_addr", memAddress, 32'h0);
    rst = 1'b1; cpu_last = 32'h0; ldr_last = 32'h0;
  endtask

  // scoreboard: each ack pops the value its fire pushed
  always @(negedge clk) begin
    if (cpuAck) begin
      cpu_ack_cnt++; cpu_streak++;
      if (cpu_streak > cpu_streak_max) cpu_streak_max = cpu_streak;
      if (cpu_q.size() == 0) check_eq("cpu_ack_unexpected", {31'h0, cpuAck}, 32'h0);
      else check_eq("cpu_rdata", cpuReadData, cpu_q.pop_front());
    end else cpu_streak = 0;
    if (ldrAck) begin
      ldr_ack_cnt++;
      if (ldr_q.size() == 0) check_eq("ldr_ack_unexpected", {31'h0, ldrAck}, 32'h0);
      else check_eq("ldr_rdata", ldrReadData, ldr_q.pop_front());
    end
    if (cpuGrant || ldrGrant) check_eq("grant_exclusive", {31'h0, cpuGrant & ldrGrant}, 32'h0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int s, f0, f1, f2, fa, fb, cf, b;
    int lf[9];
    int bf[4];
    logic [31:0] b2b_exp[4];
    cpuAddress = '0; cpuData = '0; cpuWriteMode = MEM_NONE; cpuReadMode = MEM_NONE;
    cpuUnsignedLoad = 1'b0; ldrAddress = '0; ldrData = '0; ldrWriteMode = MEM_NONE;
    ldrReadMode = MEM_NONE; ldrUnsignedLoad = 1'b0;
    apply_reset();

    // reset asserted while a loader write is about to fire
    ldrWriteMode = MEM_WORD; ldrReadMode = MEM_NONE; ldrAddress = 32'd65532;
    ldrData = 32'hDEADBEEF; ldrReq = 1'b1; b = 0;
    while (!ldrGrant && b < 20) begin @(negedge clk); b++; end
    check_eq("abort_grant", {31'h0, ldrGrant}, 32'h1);
    rst = 1'b0; #1;
    check_eq("abort_wmode", {29'h0, memWriteMode}, {29'h0, MEM_NONE});
    check_eq("abort_grant_drop", {31'h0, ldrGrant}, 32'h0);
    ldrReq = 1'b0;
    @(negedge clk); rst = 1'b1;
    s = cyc;
    cpu_txn(MEM_NONE, MEM_WORD, 1'b0, 32'd65532, 32'h0, 32'h0, f0);
    check_eq("first_grant_idle", 32'(f0 - s), 32'd1);
    cpuReq = 1'b0;
    repeat (3) @(negedge clk);

    // single CPU write then read
    s = cyc;
    cpu_txn(MEM_WORD, MEM_NONE, 1'b0, 32'd65532, 32'h22345678, 32'h0, f1);
    cpu_txn(MEM_NONE, MEM_WORD, 1'b0, 32'd65532, 32'h0, 32'h22345678, f2);
    check_eq("cpu_grant_idle", 32'(f1 - s), 32'd1);
    check_eq("cpu_b2b_wr_rd", 32'(f2 - f1), 32'd1);
    cpuReq = 1'b0;
    repeat (3) @(negedge clk);

    // tie from IDLE after reset: CPU first, loader straight after CPU drops
    apply_reset();
    s = cyc;
    fork
      begin cpu_txn(MEM_NONE, MEM_WORD, 1'b0, 32'd65532, 32'h0, 32'h22345678, fa); cpuReq = 1'b0; end
      begin ldr_txn(MEM_NONE, MEM_WORD, 1'b0, 32'd65524, 32'h0, 32'h0, fb); ldrReq = 1'b0; end
    join
    check_eq("tie_cpu_first", 32'(fa - s), 32'd1);
    check_eq("tie_handover", 32'(fb - fa), 32'd2);
    repeat (3) @(negedge clk);

    // starvation bound: loader streams while CPU waits
    fork
      begin
        for (int i = 0; i < 8; i++)
          ldr_txn(MEM_BYTE, MEM_NONE, 1'b0, 32'd65528 + 32'(i),
                  32'(8'hA1 + 8'(i) * 8'h11), 32'h0, lf[i]);
        ldr_txn(MEM_BYTE, MEM_NONE, 1'b0, 32'd65520, 32'h5A, 32'h0, lf[8]);
        ldrReq = 1'b0;
      end
      begin
        b = 0;
        while (!ldrGrant && b < 20) begin @(negedge clk); b++; end
        cpu_txn(MEM_NONE, MEM_HALF, 1'b1, 32'd65528, 32'h0, 32'h0000B2A1, cf);
        cpuReq = 1'b0;
      end
    join
    for (int i = 1; i < 8; i++) check_eq("starve_ldr_stream", 32'(lf[i] - lf[i-1]), 32'd1);
    check_eq("starve_cpu_after_8", 32'(cf - lf[7]), 32'd1);
    check_eq("starve_ldr_resume", 32'(lf[8] - cf), 32'd2);
    repeat (3) @(negedge clk);

    // sign handling is Memory's; the arbiter just forwards unsignedLoad
    ldr_txn(MEM_WORD, MEM_NONE, 1'b0, 32'd65528, 32'h0000FFFF, 32'h0, f0);
    ldrReq = 1'b0;
    cpu_txn(MEM_NONE, MEM_HALF, 1'b0, 32'd65528, 32'h0, 32'hFFFFFFFF, f1);
    cpu_txn(MEM_NONE, MEM_HALF, 1'b1, 32'd65528, 32'h0, 32'h0000FFFF, f2);
    cpuReq = 1'b0;
    repeat (3) @(negedge clk);

    // back-to-back CPU reads
    b2b_exp[0] = 32'h0000005A; b2b_exp[1] = 32'h0;
    b2b_exp[2] = 32'h0000FFFF; b2b_exp[3] = 32'h1807F6E5;
    for (int i = 0; i < 4; i++)
      cpu_txn(MEM_NONE, MEM_WORD, 1'b0, 32'd65520 + 32'(4 * i), 32'h0, b2b_exp[i], bf[i]);
    cpuReq = 1'b0;
    for (int i = 1; i < 4; i++) check_eq("b2b_fire_rate", 32'(bf[i] - bf[i-1]), 32'd1);
    repeat (4) @(negedge clk);

    check_eq("cpu_ack_streak", 32'(cpu_streak_max), 32'd4);
    check_eq("cpu_ack_total", 32'(cpu_ack_cnt), 32'd11);
    check_eq("ldr_ack_total", 32'(ldr_ack_cnt), 32'd11);
    check_eq("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check_eq("ldr_q_drained", 32'(ldr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
